// File: rtl/hum_actuator_seq.sv
// rtl/hum_actuator_seq.sv - humidifier/dehumidifier sequencer with debounce, minimum on-time and dead-time
module hum_actuator_seq #(
    parameter int DEBOUNCE  = 4,
    parameter int MIN_ON    = 16,
    parameter int DEAD_TIME = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       enable,
    input  logic [1:0] status,
    input  logic       clear_fault,
    output logic       humidifier,
    output logic       dehumidifier,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_DEAD     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_HUM_ON   = 3'd2,
        ST_DEHUM_ON = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    localparam logic [7:0] DEB_L  = 8'(DEBOUNCE);
    localparam logic [7:0] MIN_L  = 8'(MIN_ON);
    localparam logic [7:0] DEAD_L = 8'(DEAD_TIME);

    localparam logic [1:0] REQ_HUM   = 2'd1;
    localparam logic [1:0] REQ_DEHUM = 2'd2;
    localparam logic [1:0] SENSOR_ER = 2'd3;

    state_t     state_q, state_d;
    logic [7:0] timer_q;
    logic [7:0] deb_cnt_q;
    logic [1:0] last_status_q;
    logic       humidifier_q, dehumidifier_q, fault_q;
    logic       req_valid;
    logic [1:0] req;

    // The debounced request is only trusted once the sample has held for DEBOUNCE ticks.
    assign req_valid = (deb_cnt_q == DEB_L);
    assign req       = last_status_q;

    // Next-state decision; a sensor error wins over everything, including the minimum on-time.
    always_comb begin
        state_d = state_q;
        if (status == SENSOR_ER) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_DEAD: begin
                    if (timer_q >= DEAD_L) state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (enable && req_valid) begin
                        if (req == REQ_HUM)        state_d = ST_HUM_ON;
                        else if (req == REQ_DEHUM) state_d = ST_DEHUM_ON;
                    end
                end
                ST_HUM_ON: begin
                    if ((timer_q >= MIN_L) && (!enable || !req_valid || (req != REQ_HUM)))
                        state_d = ST_DEAD;
                end
                ST_DEHUM_ON: begin
                    if ((timer_q >= MIN_L) && (!enable || !req_valid || (req != REQ_DEHUM)))
                        state_d = ST_DEAD;
                end
                ST_FAULT: begin
                    // status is known not to be a sensor error here
                    if (clear_fault) state_d = ST_DEAD;
                end
                default: state_d = ST_FAULT;
            endcase
        end
    end

    // State register, state timer, debounce and registered drives; reset forces everything off at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_DEAD;
            timer_q        <= 8'd0;
            deb_cnt_q      <= 8'd0;
            last_status_q  <= 2'd0;
            humidifier_q   <= 1'b0;
            dehumidifier_q <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            humidifier_q   <= (state_d == ST_HUM_ON);
            dehumidifier_q <= (state_d == ST_DEHUM_ON);
            fault_q        <= (state_d == ST_FAULT);

            if (state_d != state_q) begin
                timer_q <= 8'd0;
            end else if (tick && (timer_q != 8'hFF)) begin
                timer_q <= timer_q + 8'd1;
            end

            if (tick) begin
                if (status == last_status_q) begin
                    if (deb_cnt_q < DEB_L) deb_cnt_q <= deb_cnt_q + 8'd1;
                end else begin
                    last_status_q <= status;
                    deb_cnt_q     <= 8'd1;
                end
            end
        end
    end

    assign humidifier   = humidifier_q;
    assign dehumidifier = dehumidifier_q;
    assign fault        = fault_q;
    assign state        = state_q;

endmodule

// File: tb/tb_hum_actuator_seq.sv
// tb/tb_hum_actuator_seq.sv - directed-vector bench for hum_actuator_seq
module tb_hum_actuator_seq;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       enable;
    logic [1:0] status;
    logic       clear_fault;
    logic       humidifier;
    logic       dehumidifier;
    logic       fault;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    hum_actuator_seq #(
        .DEBOUNCE (2),
        .MIN_ON   (4),
        .DEAD_TIME(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .enable      (enable),
        .status      (status),
        .clear_fault (clear_fault),
        .humidifier  (humidifier),
        .dehumidifier(dehumidifier),
        .fault       (fault),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input int s);
        chk($sformatf("%s.state", tag), int'(state), s);
        chk($sformatf("%s.hum", tag), int'(humidifier), int'(s == 2));
        chk($sformatf("%s.dehum", tag), int'(dehumidifier), int'(s == 3));
        chk($sformatf("%s.fault", tag), int'(fault), int'(s == 4));
        chk($sformatf("%s.excl", tag), int'(humidifier & dehumidifier), 0);
    endtask

    task automatic run_expect(input string tag, input int s);
        step();
        expect_state(tag, s);
    endtask

    initial begin
        int exp_start[5] = '{0, 0, 0, 1, 2};
        int exp_e;

        rst = 1'b1; tick = 1'b1; enable = 1'b1; status = 2'd1; clear_fault = 1'b0;
        step();
        step();
        expect_state("reset", 0);

        // power-up: dead time, then humidify once the request is debounced
        rst = 1'b0;
        for (int i = 0; i < 5; i++) run_expect($sformatf("start%0d", i + 1), exp_start[i]);

        // request drop inside the minimum on-time is held off
        run_expect("hum_t1", 2);
        status = 2'd0;
        for (int i = 7; i <= 9; i++)  run_expect($sformatf("drop%0d", i), 2);
        for (int i = 10; i <= 13; i++) run_expect($sformatf("drop%0d", i), 0);
        run_expect("drop14", 1);
        run_expect("drop15", 1);

        // humidify, then reversal to dehumidify through dead time and idle
        status = 2'd1;
        run_expect("rev16", 1);
        run_expect("rev17", 1);
        run_expect("rev18", 2);
        status = 2'd2;
        for (int i = 19; i <= 22; i++) run_expect($sformatf("rev%0d", i), 2);
        for (int i = 23; i <= 26; i++) run_expect($sformatf("rev%0d", i), 0);
        run_expect("rev27", 1);
        run_expect("rev28", 3);

        // sensor error during dehumidify, then fault clearing
        status = 2'd3;
        run_expect("flt29", 4);
        clear_fault = 1'b1;
        run_expect("flt30_blocked", 4);
        status = 2'd0;
        run_expect("flt31_clear", 0);
        clear_fault = 1'b0;
        status = 2'd1;
        enable = 1'b0;
        for (int i = 32; i <= 34; i++) run_expect($sformatf("dis%0d", i), 0);
        for (int i = 35; i <= 37; i++) run_expect($sformatf("dis%0d", i), 1);
        enable = 1'b1;
        run_expect("en38", 2);

        // sparse tick: timers scale, a between-tick glitch is not sampled
        rst = 1'b1;
        step();
        rst = 1'b0;
        status = 2'd1;
        for (int i = 1; i <= 32; i++) begin
            tick   = ((i % 4) == 0);
            status = ((i == 13) || (i >= 15)) ? 2'd0 : 2'd1;
            if (i <= 12)      exp_e = 0;
            else if (i == 13) exp_e = 1;
            else if (i <= 28) exp_e = 2;
            else              exp_e = 0;
            run_expect($sformatf("slow%0d", i), exp_e);
        end
        tick = 1'b1;

        // asynchronous reset in the middle of an on-period
        rst = 1'b1;
        step();
        rst = 1'b0;
        status = 2'd1;
        for (int i = 0; i < 5; i++) run_expect($sformatf("pre%0d", i + 1), exp_start[i]);
        #3;
        rst = 1'b1;
        #1;
        chk("async.hum", int'(humidifier), 0);
        chk("async.state", int'(state), 0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) run_expect($sformatf("post%0d", i + 1), exp_start[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
